// File: rtl/sr_cmd_conditioner_pkg.sv
// Shared constants for the SR command conditioner: FSM encodings and parameter defaults.
package sr_cmd_conditioner_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned HOLDOFF_CYCLES_DEF  = 8;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StPulse   = 2'd1;
    localparam logic [1:0] StHoldoff = 2'd2;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer plus debounce counter; emits a registered one-cycle
// pulse after the debounced level rises.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam logic [7:0] LastCnt = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q;
    logic [7:0] cnt_q;
    logic       level_q;
    logic       level_prev_q;
    logic       rise_q;

    // Synchronize, count disagreeing cycles, flip level once stable long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b00;
            cnt_q        <= 8'd0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            if (sync_q[1] != level_q) begin
                if (cnt_q == LastCnt) begin
                    level_q <= ~level_q;
                    cnt_q   <= 8'd0;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end else begin
                cnt_q <= 8'd0;
            end
            level_prev_q <= level_q;
            rise_q       <= level_q & ~level_prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns two bouncy push-buttons into clean, arbitrated one-cycle set/reset
// pulses for a downstream SR latch, with a lockout after each pulse.
module sr_cmd_conditioner
    import sr_cmd_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_rst,
    output logic s,
    output logic r,
    output logic conflict,
    output logic busy
);

    localparam logic [7:0] LastHold = 8'(HOLDOFF_CYCLES - 1);

    logic       set_rise, clr_rise;
    logic [1:0] state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       pend_set_q, pend_set_d;
    logic       pend_clr_q, pend_clr_d;
    logic       set_take, clr_take;
    logic       s_q, s_d, r_q, r_d, conflict_q, conflict_d, busy_q, busy_d;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_filter (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_set),
        .rise (set_rise)
    );

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_filter (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_rst),
        .rise (clr_rise)
    );

    // Next-state: arbitrate pending requests in IDLE (clear wins), then pulse and hold off.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        set_take   = 1'b0;
        clr_take   = 1'b0;
        case (state_q)
            StIdle: begin
                if (pend_clr_q) begin
                    state_d    = StPulse;
                    r_d        = 1'b1;
                    conflict_d = pend_set_q;
                    clr_take   = 1'b1;
                    set_take   = pend_set_q;
                end else if (pend_set_q) begin
                    state_d  = StPulse;
                    s_d      = 1'b1;
                    set_take = 1'b1;
                end
            end
            StPulse: begin
                hold_cnt_d = 8'd0;
                state_d    = (HOLDOFF_CYCLES == 0) ? StIdle : StHoldoff;
            end
            StHoldoff: begin
                if (hold_cnt_q == LastHold) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A rise while already pending is absorbed by the OR.
        pend_set_d = (pend_set_q & ~set_take) | set_rise;
        pend_clr_d = (pend_clr_q & ~clr_take) | clr_rise;
        busy_d     = (state_d != StIdle);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            hold_cnt_q <= 8'd0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            busy_q     <= busy_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner at default parameters.
module tb_sr_cmd_conditioner;
    import sr_cmd_conditioner_pkg::*;

    // Button driven at cycle k -> pulse visible at cycle k + DEBOUNCE + 5 in
    // monitor units (one extra for the edge that samples the drive).
    localparam int Lat = int'(DEBOUNCE_CYCLES_DEF) + 5;

    logic clk, reset, btn_set, btn_rst;
    logic s, r, conflict, busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int s_cnt, r_cnt, c_cnt, b_cnt, s_at, r_at, c_at;
    int t0, t1;

    sr_cmd_conditioner dut (
        .clk     (clk),
        .reset   (reset),
        .btn_set (btn_set),
        .btn_rst (btn_rst),
        .s       (s),
        .r       (r),
        .conflict(conflict),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (s) begin
            s_cnt++;
            if (s_at < 0) s_at = cyc;
        end
        if (r) begin
            r_cnt++;
            if (r_at < 0) r_at = cyc;
        end
        if (conflict) begin
            c_cnt++;
            if (c_at < 0) c_at = cyc;
        end
        if (busy) b_cnt++;
        if (s | r) check_val("s_r_exclusive", 32'(s & r), 32'd0);
    end

    task automatic clear_mon();
        s_cnt = 0; r_cnt = 0; c_cnt = 0; b_cnt = 0;
        s_at = -1; r_at = -1; c_at = -1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_until(input int target);
        for (int i = 0; i < 200 && cyc < target; i++) tick(1);
    endtask

    initial begin
        reset = 1'b1; btn_set = 1'b0; btn_rst = 1'b0;
        clear_mon();
        tick(3);
        check_val("rst_s", 32'(s), 32'd0);
        check_val("rst_r", 32'(r), 32'd0);
        check_val("rst_conflict", 32'(conflict), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(3);

        // Held press: one s pulse at the nominal latency, nothing on release.
        clear_mon();
        btn_set = 1'b1; t0 = cyc;
        tick(20);
        check_val("hold_s_cnt", 32'(s_cnt), 32'd1);
        check_val("hold_s_lat", 32'(s_at - t0), 32'(Lat));
        check_val("hold_r_cnt", 32'(r_cnt), 32'd0);
        check_val("hold_busy_cnt", 32'(b_cnt), 32'd9);
        clear_mon();
        btn_set = 1'b0;
        tick(20);
        check_val("release_s_cnt", 32'(s_cnt), 32'd0);
        check_val("release_r_cnt", 32'(r_cnt), 32'd0);

        // Bounce: 1,1,0,0,1,1,0,0,1,1 then held; last transition at i=8.
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            btn_set = ((i / 2) % 2 == 0);
            if (i == 8) t0 = cyc;
            tick(1);
        end
        tick(25);
        check_val("bounce_s_cnt", 32'(s_cnt), 32'd1);
        check_val("bounce_s_lat", 32'(s_at - t0), 32'(Lat));
        check_val("bounce_r_cnt", 32'(r_cnt), 32'd0);
        btn_set = 1'b0;
        tick(20);

        // Simultaneous press: clear dominates, conflict flagged in the same cycle.
        clear_mon();
        btn_set = 1'b1; btn_rst = 1'b1; t0 = cyc;
        tick(25);
        check_val("both_r_cnt", 32'(r_cnt), 32'd1);
        check_val("both_r_lat", 32'(r_at - t0), 32'(Lat));
        check_val("both_c_cnt", 32'(c_cnt), 32'd1);
        check_val("both_c_same", 32'(c_at - r_at), 32'd0);
        check_val("both_s_cnt", 32'(s_cnt), 32'd0);
        btn_set = 1'b0; btn_rst = 1'b0;
        tick(20);

        // Clear arrives during holdoff and is served on the first IDLE cycle after it.
        clear_mon();
        btn_set = 1'b1; t0 = cyc;
        tick(2);
        btn_rst = 1'b1;
        tick(30);
        check_val("hold_s_lat2", 32'(s_at - t0), 32'(Lat));
        check_val("hold_r_after", 32'(r_at - s_at), 32'd10);
        check_val("hold_r_cnt2", 32'(r_cnt), 32'd1);
        check_val("hold_busy_total", 32'(b_cnt), 32'd18);
        btn_set = 1'b0; btn_rst = 1'b0;
        tick(20);

        // Reset during the pulse cycle aborts everything.
        clear_mon();
        btn_set = 1'b1; t0 = cyc;
        tick_until(t0 + Lat);
        check_val("pre_abort_s", 32'(s), 32'd1);
        reset = 1'b1; btn_set = 1'b0;
        tick(1);
        check_val("abort_s", 32'(s), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        tick(1);
        reset = 1'b0;
        clear_mon();
        tick(30);
        check_val("abort_s_cnt", 32'(s_cnt), 32'd0);
        check_val("abort_r_cnt", 32'(r_cnt), 32'd0);
        check_val("abort_busy_cnt", 32'(b_cnt), 32'd0);

        // Button held through reset counts as a fresh press after release.
        btn_set = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(3);
        clear_mon();
        reset = 1'b0; t1 = cyc;
        tick(25);
        check_val("held_rst_s_cnt", 32'(s_cnt), 32'd1);
        check_val("held_rst_s_lat", 32'(s_at - t1), 32'(Lat));
        btn_set = 1'b0;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
